sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO, successor to the team's fixed 8x16 FIFO, for buffering data between producer and consumer logic in one clock domain.
- Generalised in data width, depth and almost-full/almost-empty thresholds.
- Adds true simultaneous read/write, an occupancy count and wrap-bit pointers, so all DEPTH entries are usable.
- Optional sticky overflow/underflow error flags.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of 2, >=2
AF_LEVEL, 14, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
(derived localparam ADDR_W = $clog2(DEPTH))

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
wr  input  1  write request
rd  input  1  read request
data_in  input  DATA_W  write data
data_out  output  DATA_W  registered read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  ADDR_W+1  current occupancy, 0..DEPTH
overflow  output  1  (FIFO_ERR_FLAGS_EN only) sticky write-when-full
underflow  output  1  (FIFO_ERR_FLAGS_EN only) sticky read-when-empty

Behaviour:
- Reset (rst=1 at a clock edge), with priority over wr/rd:
  - wr_ptr=0, rd_ptr=0, count=0, data_out=0.
  - Resulting outputs: empty=1, full=0, almost_empty=1, almost_full=0; overflow=0 and underflow=0 when compiled in.
  - Memory contents are not cleared and are don't-care after reset.
- Pointers are ADDR_W+1 bits. Memory is indexed by the low ADDR_W bits; the MSB is the wrap bit.
  - empty when pointers are equal.
  - full when the MSBs differ and the low bits are equal.
  - count is held as a register, always equal to wr_ptr - rd_ptr modulo 2^(ADDR_W+1).
- Flags are combinational from the registered pointers/count. They are glitch-free relative to clk and never depend on wr/rd in the same cycle.
- Write accepted iff wr=1 and full=0, using the flag value before the edge: mem[wr_ptr]<=data_in, wr_ptr+1.
- Read accepted iff rd=1 and empty=0, using the flag value before the edge: data_out<=mem[rd_ptr], rd_ptr+1.
  - Read latency is 1 cycle: data appears on data_out the cycle after rd is sampled.
  - data_out holds its last value when no read is accepted.
- Write and read are evaluated independently; there is no write-over-read priority as in the previous generation.
  - Both accepted: count unchanged.
  - Write only: count+1.
  - Read only: count-1.
- Simultaneous wr and rd when full: only the read is accepted, count becomes DEPTH-1, and the write data is dropped.
- Simultaneous wr and rd when empty: only the write is accepted, count becomes 1, data_out unchanged. There is no bypass/fall-through.
- Rejected requests (wr when full, rd when empty) have no effect on pointers, count, memory or data_out.
- Wrap-around: pointers roll over modulo 2^(ADDR_W+1) with no special handling. FIFO order is preserved across the wrap.
- Reset asserted mid-operation: all state returns to the reset values at that edge. Any wr/rd in the same cycle is ignored. Stored data is lost.

Optional Feature:
Macro FIFO_ERR_FLAGS_EN.
- Defined:
  - Output ports overflow and underflow exist.
  - overflow sets on any edge with wr=1 and full=1; underflow sets on any edge with rd=1 and empty=1.
  - Both are sticky; only rst clears them.
  - The request that set the flag is still rejected as above.
- Not defined: both ports and their logic are absent. All other behaviour is identical.

Test Plan:
All scenarios use DATA_W=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2.
1. Reset, then write 0x01..0x10 on 16 consecutive cycles, then a 17th write of 0xFF -> full=1 and count=16 after the 16th write; the 17th write is ignored. Then read 16 times -> data_out = 0x01..0x10, each 1 cycle after its rd; empty=1 and count=0 at end; 0xFF never appears.
2. Wrap: write 10 words and read 10, then write 0x20..0x2F (16 words) and read 16 -> data_out = 0x20..0x2F in order; full=1 reached with pointers wrapped.
3. Simultaneous access:
   - At count=5, wr=rd=1 for 4 cycles -> count stays 5, data in order.
   - At full, wr=rd=1 -> count=15, write dropped.
   - At empty, wr=rd=1 with data 0xAA -> count=1, data_out unchanged, next rd returns 0xAA.
4. Thresholds:
   - Write 13 -> almost_full=0; 14th write -> almost_full=1.
   - Read down from 3 to 2 -> almost_empty=1; back up to 3 -> almost_empty=0.
5. Reset mid-stream: count=7, rst=1 for 1 cycle with wr=1, data 0x55 -> count=0, empty=1, data_out=0x00; subsequent rd returns nothing and leaves data_out at 0x00.
6. With FIFO_ERR_FLAGS_EN:
   - wr at full -> overflow=1, and it stays 1 through later normal traffic until rst.
   - rd at empty -> underflow=1, with data_out unchanged.

Source files
------------

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_param
// Description : Parametrised single-clock FIFO with wrap-bit pointers,
//               registered occupancy count, almost-full/almost-empty flags and
//               a registered read port (1-cycle read latency).
//               Optional sticky overflow/underflow flags: define
//               FIFO_ERR_FLAGS_EN to build the overflow and underflow ports.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr,
    input  logic                    rd,
    input  logic [DATA_W-1:0]       data_in,
    output logic [DATA_W-1:0]       data_out,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic                    overflow,
    output logic                    underflow
`endif
);

    localparam int ADDR_W = $clog2(DEPTH);

    // Thresholds narrowed to the count width so the flag compares are exact.
    localparam logic [ADDR_W:0] c_af_level = AF_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] c_ae_level = AE_LEVEL[ADDR_W:0];

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if (DATA_W < 1) begin : g_bad_data_w
        $error("sync_fifo_param: DATA_W must be >= 1");
    end

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of 2 and >= 2");
    end

    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af_level
        $error("sync_fifo_param: AF_LEVEL must be in 1..DEPTH");
    end

    if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae_level
        $error("sync_fifo_param: AE_LEVEL must be in 0..DEPTH-1");
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [DATA_W-1:0] r_data_out;

    logic              w_full;
    logic              w_empty;
    logic              w_wr_en;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [ADDR_W-1:0] w_rd_addr;

    assign w_wr_addr = r_wr_ptr[ADDR_W-1:0];
    assign w_rd_addr = r_rd_ptr[ADDR_W-1:0];

    // Flags come only from registered pointers/count, never from wr/rd.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                     (w_wr_addr == w_rd_addr);

    // Write and read are qualified independently against pre-edge flags.
    assign w_wr_en = wr && !w_full;
    assign w_rd_en = rd && !w_empty;

    // ------------------------------------------------------------------------
    // Storage array: intentionally not reset, contents are don't-care
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && w_wr_en) begin
            r_mem[w_wr_addr] <= data_in;
        end
    end

    // ------------------------------------------------------------------------
    // Pointers, occupancy and read data
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_data_out <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            if (w_rd_en) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_data_out <= r_mem[w_rd_addr];
            end

            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign data_out     = r_data_out;
    assign count        = r_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_af_level);
    assign almost_empty = (r_count <= c_ae_level);

`ifdef FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky: set by a rejected request, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr && w_full) begin
                r_overflow <= 1'b1;
            end
            if (rd && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_param
// Description : Self-checking bench for sync_fifo_param: directed scenarios
//               plus randomized traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

    localparam int DATA_W   = 8;
    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = 14;
    localparam int AE_LEVEL = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              wr  = 1'b0;
    logic              rd  = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic [DATA_W-1:0] data_out;
    logic              full, empty, almost_full, almost_empty;
    logic [4:0]        count;
`ifdef FIFO_ERR_FLAGS_EN
    logic              overflow, underflow;
`endif

    sync_fifo_param #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .AF_LEVEL(AF_LEVEL),
        .AE_LEVEL(AE_LEVEL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr          (wr),
        .rd          (rd),
        .data_in     (data_in),
        .data_out    (data_out),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .overflow    (overflow),
        .underflow   (underflow)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: plain FIFO contents plus sticky error bits.
    logic [DATA_W-1:0] model_q[$];
    logic              model_ovf = 1'b0;
    logic              model_udf = 1'b0;

    // Scoreboard: expected data_out values, one entry per output update.
    logic [DATA_W-1:0] exp_q[$];
    logic              mon_en = 1'b0;
    logic [DATA_W-1:0] mon_last = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: data_out must equal the newest expected read result.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                mon_last = exp_q.pop_front();
            end
            check("data_out", 32'(data_out), 32'(mon_last));
        end
    end

    // One clock of stimulus; model updated from its pre-edge occupancy.
    task automatic cycle(input logic r, input logic w, input logic rdq, input logic [DATA_W-1:0] d);
        int  sz;
        bit  wa, ra;
        @(negedge clk);
        rst     = r;
        wr      = w;
        rd      = rdq;
        data_in = d;
        sz = model_q.size();
        wa = w   && (sz < DEPTH);
        ra = rdq && (sz > 0);
        @(posedge clk);
        #1;
        if (r) begin
            model_q.delete();
            model_ovf = 1'b0;
            model_udf = 1'b0;
            exp_q.push_back('0);
            mon_en = 1'b1;
        end else begin
            if (w && sz == DEPTH) model_ovf = 1'b1;
            if (rdq && sz == 0)   model_udf = 1'b1;
            if (ra) exp_q.push_back(model_q.pop_front());
            if (wa) model_q.push_back(d);
        end
        sz = model_q.size();
        check("count",        32'(count),        32'(sz));
        check("empty",        32'(empty),        32'(sz == 0));
        check("full",         32'(full),         32'(sz == DEPTH));
        check("almost_full",  32'(almost_full),  32'(sz >= AF_LEVEL));
        check("almost_empty", 32'(almost_empty), 32'(sz <= AE_LEVEL));
`ifdef FIFO_ERR_FLAGS_EN
        check("overflow",     32'(overflow),     32'(model_ovf));
        check("underflow",    32'(underflow),    32'(model_udf));
`endif
    endtask

    task automatic write_n(input int n, input logic [DATA_W-1:0] first);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, DATA_W'(first + i));
    endtask

    task automatic read_n(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1, DATA_W'($urandom));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        // Fill to full, one rejected write, drain in order.
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        write_n(16, 8'h01);
        cycle(1'b0, 1'b1, 1'b0, 8'hFF);
        read_n(16);
        read_n(1);

        // Wrap-around: offset pointers then fill/drain completely.
        write_n(10, 8'h40);
        read_n(10);
        write_n(16, 8'h20);
        read_n(16);

        // Simultaneous access at mid-level, at full and at empty.
        write_n(5, 8'h60);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, DATA_W'(8'h70 + i));
        read_n(5);
        write_n(16, 8'h80);
        cycle(1'b0, 1'b1, 1'b1, 8'hEE);
        read_n(15);
        cycle(1'b0, 1'b1, 1'b1, 8'hAA);
        read_n(1);

        // Threshold crossings.
        write_n(14, 8'h90);
        read_n(11);
        read_n(1);
        write_n(1, 8'hB0);
        read_n(4);

        // Reset in the middle of traffic, with a write pending.
        write_n(7, 8'hC0);
        cycle(1'b1, 1'b1, 1'b0, 8'h55);
        read_n(1);

`ifdef FIFO_ERR_FLAGS_EN
        write_n(16, 8'hD0);
        cycle(1'b0, 1'b1, 1'b0, 8'hDE);
        read_n(16);
        write_n(3, 8'hE0);
        read_n(4);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        read_n(1);
`endif

        // Randomized traffic with varying read/write bias and rare resets.
        for (int blk = 0; blk < 12; blk++) begin
            int pw, pr;
            pw = $urandom_range(20, 90);
            pr = $urandom_range(20, 90);
            for (int i = 0; i < 200; i++) begin
                cycle(($urandom_range(0, 299) == 0),
                      ($urandom_range(0, 99) < pw),
                      ($urandom_range(0, 99) < pr),
                      DATA_W'($urandom));
            end
        end

        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
